div_reconstructor: RTL and testbench

//  Sequential inverse of the combinational divider: computes quotient*divisor + remainder
//  by iterative shift-add, one quotient bit per clock.

---
 rtl/div_reconstructor.sv | 145 ++++++++++++++
 tb/tb_div_reconstructor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_reconstructor.sv
// Sequential shift-add reconstructor: product = quotient*divisor + remainder, one bit per clock.
// Optional DIV_RECON_CHECK_EN adds a dividend input and a registered match flag.
module div_reconstructor #(
  parameter int unsigned BITS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [BITS-1:0]   quotient_i,
  input  logic [BITS-1:0]   divisor_i,
  input  logic [BITS-1:0]   remainder_i,
`ifdef DIV_RECON_CHECK_EN
  input  logic [BITS-1:0]   dividend_i,
  output logic              match_o,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [2*BITS-1:0] product_o,
  output logic              overflow_o
);

  localparam int unsigned IdxW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [2*BITS-1:0] acc_q, acc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [BITS-1:0]   quot_q, quot_d;
  logic [BITS-1:0]   div_q, div_d;
  logic [2*BITS-1:0] prod_q, prod_d;
  logic              ovf_q, ovf_d;
  logic [2*BITS-1:0] acc_step;
  logic              accept;

`ifdef DIV_RECON_CHECK_EN
  logic [BITS-1:0]   dvd_q, dvd_d;
  logic              match_q, match_d;
`endif

  // Partial product for the current quotient bit, added into the running sum.
  always_comb begin
    acc_step = acc_q;
    if (quot_q[idx_q]) begin
      acc_step = acc_q + ({{BITS{1'b0}}, div_q} << idx_q);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    quot_d  = quot_q;
    div_d   = div_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;
`ifdef DIV_RECON_CHECK_EN
    dvd_d   = dvd_q;
    match_d = match_q;
`endif

    unique case (state_q)
      StIdle: begin
        accept = start_i;
      end
      StRun: begin
        acc_d = acc_step;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d = StDone;
          // Outputs only ever see the completed sum.
          prod_d  = acc_step;
          ovf_d   = |acc_step[2*BITS-1:BITS];
`ifdef DIV_RECON_CHECK_EN
          match_d = (acc_step == {{BITS{1'b0}}, dvd_q});
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
        accept  = start_i;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      state_d = StRun;
      quot_d  = quotient_i;
      div_d   = divisor_i;
      acc_d   = {{BITS{1'b0}}, remainder_i};
      idx_d   = '0;
`ifdef DIV_RECON_CHECK_EN
      dvd_d   = dividend_i;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      idx_q   <= '0;
      quot_q  <= '0;
      div_q   <= '0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      quot_q  <= quot_d;
      div_q   <= div_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DIV_RECON_CHECK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dvd_q   <= '0;
      match_q <= 1'b0;
    end else begin
      dvd_q   <= dvd_d;
      match_q <= match_d;
    end
  end

  assign match_o = match_q;
`endif

  assign busy_o     = (state_q == StRun);
  assign done_o     = (state_q == StDone);
  assign product_o  = prod_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_div_reconstructor.sv
// Self-checking bench for div_reconstructor against a plain-arithmetic model q*d + r.
module tb_div_reconstructor;

  localparam int BITS = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [BITS-1:0] quotient = '0;
  logic [BITS-1:0] divisor = '0;
  logic [BITS-1:0] remainder = '0;
  logic            busy;
  logic            done;
  logic [2*BITS-1:0] product;
  logic            overflow;
`ifdef DIV_RECON_CHECK_EN
  logic [BITS-1:0] dividend = '0;
  logic            match;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_reconstructor #(.BITS(BITS)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .quotient_i  (quotient),
    .divisor_i   (divisor),
    .remainder_i (remainder),
`ifdef DIV_RECON_CHECK_EN
    .dividend_i  (dividend),
    .match_o     (match),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .product_o   (product),
    .overflow_o  (overflow)
  );

  // Caller sits just after a rising edge; start is accepted on the next edge.
  task automatic run_op(input logic [BITS-1:0] q, input logic [BITS-1:0] d,
                        input logic [BITS-1:0] r, input logic [BITS-1:0] dv,
                        output logic [2*BITS-1:0] prod, output logic ov, output logic m,
                        output int lat, output int busy_cycles, output logic held);
    logic [2*BITS-1:0] p0;
    quotient  = q;
    divisor   = d;
    remainder = r;
`ifdef DIV_RECON_CHECK_EN
    dividend  = dv;
`endif
    start = 1'b1;
    p0 = product;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands are latched, so scramble them while running.
    quotient  = BITS'($urandom);
    divisor   = BITS'($urandom);
    remainder = BITS'($urandom);
`ifdef DIV_RECON_CHECK_EN
    dividend  = BITS'($urandom);
`endif
    lat = 0;
    busy_cycles = 0;
    held = 1'b1;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      if (product !== p0) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    prod = product;
    ov   = overflow;
`ifdef DIV_RECON_CHECK_EN
    m = match;
`else
    m = 1'b0;
    if (dv == '1) m = 1'b0;
`endif
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b product=%0d overflow=%b, required all 0",
               busy, done, product, overflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [2*BITS-1:0] p; logic ov, m, held; int lat, bc;
    run_op(4'd3, 4'd4, 4'd2, 4'd14, p, ov, m, lat, bc, held);
    vectors++;
    if (lat !== BITS) begin
      miscompares++; $display("FAIL basic_latency: got %0d edges, required %0d", lat, BITS);
    end
    vectors++;
    if (bc !== BITS) begin
      miscompares++; $display("FAIL basic_busy: busy %0d cycles, required %0d", bc, BITS);
    end
    vectors++;
    if (p !== 8'd14 || ov !== 1'b0) begin
      miscompares++; $display("FAIL basic_product: got %0d ov=%b, required 14 ov=0", p, ov);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || product !== 8'd14) begin
      miscompares++;
      $display("FAIL basic_one_pulse: done=%b product=%0d, required done=0 product=14",
               done, product);
    end
  endtask

  task automatic test_overflow;
    logic [2*BITS-1:0] p; logic ov, m, held; int lat, bc;
    run_op(4'd15, 4'd15, 4'd15, 4'd0, p, ov, m, lat, bc, held);
    vectors++;
    if (p !== 8'hF0 || ov !== 1'b1) begin
      miscompares++; $display("FAIL overflow_product: got %0d ov=%b, required 240 ov=1", p, ov);
    end
`ifdef DIV_RECON_CHECK_EN
    vectors++;
    if (m !== 1'b0) begin
      miscompares++; $display("FAIL overflow_match: got %b, required 0", m);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    logic [2*BITS-1:0] p = '0;
    quotient = 4'd2; divisor = 4'd5; remainder = 4'd1;
    start = 1'b1;
    @(posedge clk); #1;
    quotient = 4'd7;
    for (int i = 0; i < 12; i++) begin
      start = busy;
      if (done) begin
        pulses++;
        p = product;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    vectors++;
    if (pulses !== 1) begin
      miscompares++; $display("FAIL ignore_pulses: got %0d done pulses, required 1", pulses);
    end
    vectors++;
    if (p !== 8'd11) begin
      miscompares++; $display("FAIL ignore_product: got %0d, required 11", p);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    quotient = 4'd5; divisor = 4'd5; remainder = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b product=%0d overflow=%b, required all 0",
               busy, done, product, overflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    vectors++;
    if (pulses !== 0 || product !== '0) begin
      miscompares++;
      $display("FAIL reset_no_done: pulses=%0d product=%0d, required 0 and 0", pulses, product);
    end
  endtask

  task automatic test_zero_divisor;
    logic [2*BITS-1:0] p; logic ov, m, held; int lat, bc;
    run_op(4'd15, 4'd0, 4'd9, 4'd9, p, ov, m, lat, bc, held);
    vectors++;
    if (p !== 8'd9 || ov !== 1'b0) begin
      miscompares++; $display("FAIL zero_div_product: got %0d ov=%b, required 9 ov=0", p, ov);
    end
`ifdef DIV_RECON_CHECK_EN
    vectors++;
    if (m !== 1'b1) begin
      miscompares++; $display("FAIL zero_div_match: got %b, required 1", m);
    end
    @(posedge clk); #1;
    run_op(4'd15, 4'd0, 4'd9, 4'd8, p, ov, m, lat, bc, held);
    vectors++;
    if (m !== 1'b0) begin
      miscompares++; $display("FAIL zero_div_mismatch: got %b, required 0", m);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [2*BITS-1:0] p; logic ov, m, held; int lat, bc;
    run_op(4'd3, 4'd4, 4'd2, 4'd0, p, ov, m, lat, bc, held);
    vectors++;
    if (done !== 1'b1 || p !== 8'd14) begin
      miscompares++; $display("FAIL b2b_first: done=%b product=%0d, required 1 and 14", done, p);
    end
    run_op(4'd1, 4'd1, 4'd0, 4'd1, p, ov, m, lat, bc, held);
    vectors++;
    if (held !== 1'b1) begin
      miscompares++; $display("FAIL b2b_hold: prior product changed before done, required held");
    end
    vectors++;
    if (lat !== BITS || p !== 8'd1) begin
      miscompares++;
      $display("FAIL b2b_second: lat=%0d product=%0d, required lat=%0d product=1", lat, p, BITS);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [2*BITS-1:0] p; logic ov, m, held; int lat, bc;
    int unsigned q, d, r, dv, expv;
    for (int n = 0; n < 40; n++) begin
      q = $urandom_range(15); d = $urandom_range(15); r = $urandom_range(15);
      expv = q * d + r;
      dv = ($urandom_range(1) == 1) ? (expv % 16) : $urandom_range(15);
      run_op(BITS'(q), BITS'(d), BITS'(r), BITS'(dv), p, ov, m, lat, bc, held);
      vectors++;
      if (p !== 8'(expv) || ov !== (expv > 15) || lat !== BITS || held !== 1'b1) begin
        miscompares++;
        $display("FAIL random_%0d q=%0d d=%0d r=%0d: got p=%0d ov=%b lat=%0d held=%b, required p=%0d ov=%b lat=%0d held=1",
                 n, q, d, r, p, ov, lat, held, expv, expv > 15, BITS);
      end
`ifdef DIV_RECON_CHECK_EN
      vectors++;
      if (m !== (expv == dv)) begin
        miscompares++;
        $display("FAIL random_match_%0d: got %b, required %b", n, m, expv == dv);
      end
`endif
      for (int k = $urandom_range(2); k > 0; k--) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_zero_divisor();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
